// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one dual_ram between two masters (m0 = core LSU, m1 = debug loader).
// The RAM read port and write port are arbitrated independently, so a read
// from one master and a write from the other can complete in the same cycle;
// only requests of the same type contend.  Each port has a 1-bit round-robin
// pointer that a master can pin to itself with its lock input.
// Read data comes back one cycle after the read grant and is routed to the
// owning master through a one-cycle rvalid pulse.  rst is asynchronous and
// active-low and is shared unchanged with the dual_ram instance.
module ram_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,

    // master 0: core load/store unit
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    // master 1: debug / download loader
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    // dual_ram write port
    output logic          ram_wen,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,

    // dual_ram read port
    output logic          ram_ren,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    // Per-port request decode.  Requests are masked while reset is asserted
    // so that no grant (and hence no RAM strobe) can escape during reset.
    logic w_rd_req0;
    logic w_rd_req1;
    logic w_wr_req0;
    logic w_wr_req1;

    // Per-port grants and winner identity (0 = m0, 1 = m1).
    logic w_rd_gnt0;
    logic w_rd_gnt1;
    logic w_wr_gnt0;
    logic w_wr_gnt1;
    logic w_rd_any;
    logic w_wr_any;
    logic w_rd_win;
    logic w_wr_win;
    logic w_rd_win_lock;
    logic w_wr_win_lock;
    logic w_rd_pri_nxt;
    logic w_wr_pri_nxt;

    // Arbitration state.
    logic r_rd_pri;
    logic r_wr_pri;
    logic r_rd_owner;
    logic r_rvalid;

    // Two-way grant: the pointer only matters when both masters contend.
    function automatic logic [1:0] arb_grant(input logic req0,
                                             input logic req1,
                                             input logic pri);
        logic [1:0] g;
        g[0] = req0 & (~req1 | ~pri);
        g[1] = req1 & (~req0 |  pri);
        return g;
    endfunction

    // Pointer after a grant: stay with a locking winner, else hand over.
    function automatic logic next_pri(input logic win, input logic lock);
        return lock ? win : ~win;
    endfunction

    // Split the incoming requests into read and write requests.
    always_comb begin
        w_rd_req0 = rst & m0_req & ~m0_we;
        w_rd_req1 = rst & m1_req & ~m1_we;
        w_wr_req0 = rst & m0_req &  m0_we;
        w_wr_req1 = rst & m1_req &  m1_we;
    end

    // Independent read and write arbiters plus next-pointer computation.
    always_comb begin
        {w_rd_gnt1, w_rd_gnt0} = arb_grant(w_rd_req0, w_rd_req1, r_rd_pri);
        {w_wr_gnt1, w_wr_gnt0} = arb_grant(w_wr_req0, w_wr_req1, r_wr_pri);

        w_rd_any = w_rd_gnt0 | w_rd_gnt1;
        w_wr_any = w_wr_gnt0 | w_wr_gnt1;
        w_rd_win = w_rd_gnt1;
        w_wr_win = w_wr_gnt1;

        w_rd_win_lock = w_rd_win ? m1_lock : m0_lock;
        w_wr_win_lock = w_wr_win ? m1_lock : m0_lock;

        w_rd_pri_nxt = w_rd_any ? next_pri(w_rd_win, w_rd_win_lock) : r_rd_pri;
        w_wr_pri_nxt = w_wr_any ? next_pri(w_wr_win, w_wr_win_lock) : r_wr_pri;
    end

    // A master is granted when it wins whichever port its request targets.
    always_comb begin
        m0_gnt = w_rd_gnt0 | w_wr_gnt0;
        m1_gnt = w_rd_gnt1 | w_wr_gnt1;
    end

    // Write port mux: winner's address/data, zero when idle.
    always_comb begin
        ram_wen    = w_wr_any;
        ram_w_addr = '0;
        ram_w_data = '0;
        if (w_wr_gnt0) begin
            ram_w_addr = m0_addr;
            ram_w_data = m0_wdata;
        end else if (w_wr_gnt1) begin
            ram_w_addr = m1_addr;
            ram_w_data = m1_wdata;
        end
    end

    // Read port mux: winner's address, zero when idle.
    always_comb begin
        ram_ren    = w_rd_any;
        ram_r_addr = '0;
        if (w_rd_gnt0) begin
            ram_r_addr = m0_addr;
        end else if (w_rd_gnt1) begin
            ram_r_addr = m1_addr;
        end
    end

    // Priority pointers advance only on ports that granted this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pri <= 1'b0;
            r_wr_pri <= 1'b0;
        end else begin
            r_rd_pri <= w_rd_pri_nxt;
            r_wr_pri <= w_wr_pri_nxt;
        end
    end

    // Remember who owns the read in flight; rvalid pulses for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_owner <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rvalid <= w_rd_any;
            if (w_rd_any) begin
                r_rd_owner <= w_rd_win;
            end
        end
    end

    // Response routing: data is broadcast, rvalid qualifies the owner.
    always_comb begin
        m0_rvalid = r_rvalid & ~r_rd_owner;
        m1_rvalid = r_rvalid &  r_rd_owner;
        m0_rdata  = ram_r_data;
        m1_rdata  = ram_r_data;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: includes a behavioural dual_ram (registered
// read with same-cycle write bypass) and runs directed scenarios followed by
// a randomized scoreboard run.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_wen, ram_ren;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data = '0;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] ref_mem [4096];
    int            pre_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a, a[7:0], a};
    endfunction

    // Behavioural dual_ram: preloads itself, then write-first with read bypass.
    always @(posedge clk) begin
        if (pre_cnt < 4096) begin
            mem[pre_cnt[11:0]] <= init_val(pre_cnt[11:0]);
            pre_cnt <= pre_cnt + 1;
        end else if (ram_wen) begin
            mem[ram_w_addr] <= ram_w_data;
        end
        if (ram_ren) begin
            ram_r_data <= (ram_wen && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr];
        end
    end

    ram_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    task automatic idle_masters();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 12'h005;
        m1_req = 1; m1_we = 1; m1_addr = 12'h006; m1_wdata = 32'h1;
        @(negedge clk); #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", {m0_gnt, m1_gnt}); end
        checks++; if ({ram_wen, ram_ren} !== 2'b00) begin failures++; $display("FAIL rst_ram_en got=%b exp=00", {ram_wen, ram_ren}); end
        repeat (4100) @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        checks++; if ({m0_gnt, m1_gnt, ram_wen, ram_ren} !== 4'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0000", {m0_gnt, m1_gnt, ram_wen, ram_ren}); end
        // release with only m1 reading 0x010
        m0_req = 0; m1_we = 0; m1_addr = 12'h010; rst = 1;
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin failures++; $display("FAIL rel_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
        checks++; if (ram_ren !== 1'b1 || ram_r_addr !== 12'h010) begin failures++; $display("FAIL rel_raddr got=%b/%h exp=1/010", ram_ren, ram_r_addr); end
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin failures++; $display("FAIL rel_rvalid got=%b exp=01", {m0_rvalid, m1_rvalid}); end
        checks++; if (m1_rdata !== init_val(12'h010)) begin failures++; $display("FAIL rel_rdata got=%h exp=%h", m1_rdata, init_val(12'h010)); end
        m1_req = 0;
    endtask

    task automatic test_read_rr();
        logic [AW-1:0] m0a [4] = '{12'h001, 12'h003, 12'h003, 12'h005};
        logic [AW-1:0] m1a [4] = '{12'h002, 12'h002, 12'h004, 12'h004};
        logic          win [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({m0_rvalid, m1_rvalid} !== (win[i-1] ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL rr_rvalid[%0d] got=%b", i - 1, {m0_rvalid, m1_rvalid});
                end
                checks++;
                if ((win[i-1] ? m1_rdata : m0_rdata) !== init_val(win[i-1] ? m1a[i-1] : m0a[i-1])) begin
                    failures++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", i - 1,
                        win[i-1] ? m1_rdata : m0_rdata, init_val(win[i-1] ? m1a[i-1] : m0a[i-1]));
                end
            end
            if (i < 4) begin
                m0_req = 1; m0_we = 0; m0_addr = m0a[i];
                m1_req = 1; m1_we = 0; m1_addr = m1a[i];
                #1;
                checks++;
                if ({m0_gnt, m1_gnt} !== (win[i] ? 2'b01 : 2'b10)) begin
                    failures++; $display("FAIL rr_gnt[%0d] got=%b", i, {m0_gnt, m1_gnt});
                end
                checks++;
                if (ram_r_addr !== (win[i] ? m1a[i] : m0a[i]) || ram_wen !== 1'b0) begin
                    failures++; $display("FAIL rr_raddr[%0d] got=%h wen=%b", i, ram_r_addr, ram_wen);
                end
            end else begin
                idle_masters();
            end
        end
    endtask

    task automatic test_concurrent_rw();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 12'h020; m0_wdata = 32'hDEADBEEF;
        m1_req = 1; m1_we = 0; m1_addr = 12'h020;
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b11) begin failures++; $display("FAIL crw_gnt got=%b exp=11", {m0_gnt, m1_gnt}); end
        checks++;
        if ({ram_wen, ram_ren} !== 2'b11 || ram_w_addr !== 12'h020 || ram_w_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL crw_ram got=%b %h %h", {ram_wen, ram_ren}, ram_w_addr, ram_w_data);
        end
        ref_mem[12'h020] = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin failures++; $display("FAIL crw_rvalid got=%b exp=01", {m0_rvalid, m1_rvalid}); end
        checks++; if (m1_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL crw_rdata got=%h exp=deadbeef", m1_rdata); end
        idle_masters();
    endtask

    task automatic test_lock();
        // write pointer currently favours m1 (m0 won the last write unlocked)
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            m0_req = 1; m0_we = 1; m0_addr = 12'h021; m0_wdata = 32'h11111111;
            if (b < 3) begin
                m1_req = 1; m1_we = 1; m1_lock = 1;
                m1_addr = 12'h028 + 12'(b); m1_wdata = 32'hA0000000 + b;
                #1;
                checks++;
                if ({m0_gnt, m1_gnt} !== 2'b01 || ram_w_addr !== 12'h028 + 12'(b)) begin
                    failures++; $display("FAIL lock_beat[%0d] gnt=%b waddr=%h exp=01/%h", b, {m0_gnt, m1_gnt}, ram_w_addr, 12'h028 + 12'(b));
                end
                ref_mem[12'h028 + 12'(b)] = 32'hA0000000 + b;
            end else begin
                m1_req = 0; m1_lock = 0;
                #1;
                checks++;
                if ({m0_gnt, m1_gnt} !== 2'b10 || ram_w_data !== 32'h11111111) begin
                    failures++; $display("FAIL lock_release gnt=%b wdata=%h exp=10/11111111", {m0_gnt, m1_gnt}, ram_w_data);
                end
                ref_mem[12'h021] = 32'h11111111;
            end
        end
        @(negedge clk);
        idle_masters();
    endtask

    task automatic test_async_reset();
        // m0 reads alone so the read pointer moves to m1
        m0_req = 1; m0_we = 0; m0_addr = 12'h007;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL ar_pre_gnt got=%b exp=1", m0_gnt); end
        @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(12'h007)) begin failures++; $display("FAIL ar_pre_rd got=%b/%h", m0_rvalid, m0_rdata); end
        m0_addr = 12'h008;
        #1;
        checks++; if (m0_gnt !== 1'b1) begin failures++; $display("FAIL ar_gnt got=%b exp=1", m0_gnt); end
        #1 rst = 0;
        #1;
        checks++; if ({m0_gnt, ram_ren} !== 2'b00) begin failures++; $display("FAIL ar_gnt_drop got=%b exp=00", {m0_gnt, ram_ren}); end
        @(negedge clk);
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL ar_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        m0_req = 0;
        @(negedge clk);
        rst = 1;
        // both read: pointer back at 0 so m0 wins
        m0_req = 1; m0_we = 0; m0_addr = 12'h009;
        m1_req = 1; m1_we = 0; m1_addr = 12'h00A;
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL ar_rdpri got=%b exp=10", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(12'h009)) begin failures++; $display("FAIL ar_rd9 got=%b/%h", m0_rvalid, m0_rdata); end
        m0_req = 0;
        #1;
        checks++; if (m1_gnt !== 1'b1) begin failures++; $display("FAIL ar_m1_hold got=%b exp=1", m1_gnt); end
        @(negedge clk);
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== init_val(12'h00A)) begin failures++; $display("FAIL ar_rdA got=%b/%h", m1_rvalid, m1_rdata); end
        // both write: write pointer also back at 0
        m0_req = 1; m0_we = 1; m0_addr = 12'h030; m0_wdata = 32'h33333333;
        m1_req = 1; m1_we = 1; m1_addr = 12'h031; m1_wdata = 32'h44444444;
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin failures++; $display("FAIL ar_wrpri got=%b exp=10", {m0_gnt, m1_gnt}); end
        ref_mem[12'h030] = 32'h33333333;
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++; if (m1_gnt !== 1'b1 || ram_w_addr !== 12'h031) begin failures++; $display("FAIL ar_wr_m1 got=%b/%h", m1_gnt, ram_w_addr); end
        ref_mem[12'h031] = 32'h44444444;
        @(negedge clk);
        idle_masters();
    endtask

    task automatic test_scoreboard();
        logic          p0 = 0, p1 = 0;
        logic          ev0 = 0, ev1 = 0;
        logic [DW-1:0] ed0 = '0, ed1 = '0;
        int            wait0 = 0, wait1 = 0;
        logic          gr0, gr1, gw0, gw1;
        for (int c = 0; c <= 10000; c++) begin
            @(negedge clk);
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {ev0, ev1}) begin
                failures++; $display("FAIL sb_rvalid cyc=%0d got=%b exp=%b", c, {m0_rvalid, m1_rvalid}, {ev0, ev1});
            end
            if (ev0) begin
                checks++; if (m0_rdata !== ed0) begin failures++; $display("FAIL sb_m0_rdata cyc=%0d got=%h exp=%h", c, m0_rdata, ed0); end
            end
            if (ev1) begin
                checks++; if (m1_rdata !== ed1) begin failures++; $display("FAIL sb_m1_rdata cyc=%0d got=%h exp=%h", c, m1_rdata, ed1); end
            end
            if (c == 10000) break;
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = 12'($urandom_range(0, 15));
                m0_wdata = $urandom; m0_lock = ($urandom_range(0, 3) == 0);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = 12'($urandom_range(0, 15));
                m1_wdata = $urandom; m1_lock = ($urandom_range(0, 3) == 0);
            end
            m0_req = p0; m1_req = p1;
            #1;
            gr0 = m0_gnt & ~m0_we; gw0 = m0_gnt & m0_we;
            gr1 = m1_gnt & ~m1_we; gw1 = m1_gnt & m1_we;
            checks++;
            if ((m0_gnt && !p0) || (m1_gnt && !p1)) begin
                failures++; $display("FAIL sb_spurious cyc=%0d gnt=%b req=%b", c, {m0_gnt, m1_gnt}, {p0, p1});
            end
            checks++;
            if ((gr0 && gr1) || (gw0 && gw1)) begin
                failures++; $display("FAIL sb_double cyc=%0d rd=%b wr=%b", c, {gr0, gr1}, {gw0, gw1});
            end
            checks++;
            if ((gr0 | gr1) !== ((p0 & ~m0_we) | (p1 & ~m1_we)) || (gw0 | gw1) !== ((p0 & m0_we) | (p1 & m1_we))) begin
                failures++; $display("FAIL sb_idle_port cyc=%0d rdg=%b wrg=%b", c, gr0 | gr1, gw0 | gw1);
            end
            if (gw0) ref_mem[m0_addr] = m0_wdata;
            if (gw1) ref_mem[m1_addr] = m1_wdata;
            ev0 = gr0; ed0 = ref_mem[m0_addr];
            ev1 = gr1; ed1 = ref_mem[m1_addr];
            if (m0_gnt) begin p0 = 0; wait0 = 0; end else if (p0) wait0++;
            if (m1_gnt) begin p1 = 0; wait1 = 0; end else if (p1) wait1++;
            if (wait0 > 200 || wait1 > 200) begin
                checks++; failures++;
                $display("FAIL sb_starved cyc=%0d wait0=%0d wait1=%0d limit=200", c, wait0, wait1);
                wait0 = 0; wait1 = 0;
            end
        end
        idle_masters();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
        idle_masters();
        test_reset();
        test_read_rr();
        test_concurrent_rw();
        test_lock();
        test_async_reset();
        test_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one `dual_ram` instance between two bus masters: m0 (core load/store unit) and m1 (debug/download loader). The RAM's read port and write port are arbitrated independently. A read from one master and a write from the other can therefore complete in the same cycle; only same-type requests contend. The block sits between the masters and `dual_ram`, producing its `wen/w_addr_i/w_data_i/ren/r_addr_i` and routing `r_data_o` back to the owning master.

## Interface
- `DW`, 32, data width
- `AW`, 12, word-address width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_lock`, `m1_lock`  in  1  keep priority on the granted port for back-to-back beats
- `m0_addr`, `m1_addr`  in  AW  word address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered)
- `m0_rdata`, `m1_rdata`  out  DW  read data, meaningful only while the matching rvalid is 1
- `ram_wen`  out  1  to dual_ram `wen`
- `ram_w_addr`  out  AW  to `w_addr_i`
- `ram_w_data`  out  DW  to `w_data_i`
- `ram_ren`  out  1  to `ren`
- `ram_r_addr`  out  AW  to `r_addr_i`
- `ram_r_data`  in  DW  from `r_data_o`

## Operation
- A request is a read request when `mX_req && !mX_we`, and a write request when `mX_req && mX_we`. Each master issues at most one operation per cycle.
- There are two independent arbiters, one for reads and one for writes. Each has a 1-bit priority pointer, `rd_pri` / `wr_pri`; 0 means m0 wins a conflict.
- Single requester on a port: that requester is granted.
- Both masters requesting the same port: the master selected by the pointer is granted. The loser's `gnt` is 0 and it must hold its request.
- Pointer update on a granted port, at the clock edge:
  - if the winner's `lock` is 1, the pointer is set to the winner;
  - otherwise the pointer is set to the other master.
  - Ports with no grant leave their pointer unchanged.
- Write path:
  - `ram_wen` = write grant.
  - `ram_w_addr` / `ram_w_data` come from the write winner, and are 0 when there is no grant.
- Read path:
  - `ram_ren` = read grant.
  - `ram_r_addr` comes from the read winner, and is 0 when idle.
  - A registered `rd_owner` captures the winner at the edge.
- Response: the cycle after a read grant, `mX_rvalid` = 1 for the owner only, as a one-cycle pulse.
  - Both `mX_rdata` outputs are driven with `ram_r_data`.
  - Masters must ignore rdata when rvalid = 0.
- Same-address read/write in one cycle, from different masters: the read returns the newly written data. The `dual_ram` bypass provides this; the arbiter adds nothing.
- Locked master: while its lock is held and it keeps requesting, it wins every cycle on that port. The other master starves until the lock drops. Bounding lock length is the master's responsibility.
- The `rst` input passes through unchanged to `dual_ram`.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `rd_pri`=0, `wr_pri`=0, `rd_owner`=0
  - `m0_rvalid`=0, `m1_rvalid`=0
  - `ram_wen`=0, `ram_ren`=0
  - all grants 0, regardless of requests
- Grants are combinational from req/we/lock and the pointers. The transfer occurs at the rising edge where `req && gnt`.
- Read latency: grant at edge N, data and rvalid valid in cycle N+1. The pipeline is fully throughput-capable: one read and one write per cycle.
- Write latency: memory updated at the grant edge. A read of that address granted at a later edge sees the new data.
- Reset asserted mid-operation: a pending rvalid is cleared immediately and that response is lost. After release, the first request is arbitrated with both pointers at 0.
- A `lock` with no grant on that port has no effect.

## Test plan
- **Reset:** hold `rst`=0 with both masters requesting → every grant, rvalid, `ram_wen` and `ram_ren` is 0. Release reset with only m1 reading addr 0x010 → `m1_gnt`=1, `ram_r_addr`=0x010, and `m1_rvalid`=1 next cycle with the stored word.
- **Read conflict, round-robin:** both masters read continuously for 4 cycles, no lock → grants m0, m1, m0, m1. Each rvalid follows its grant by one cycle, and the data matches the preloaded values.
- **Concurrent read/write:** in the same cycle, m0 writes 0xDEADBEEF to 0x020 and m1 reads 0x020 → both granted; `m1_rvalid`=1 next cycle with rdata 0xDEADBEEF.
- **Lock:** m1 writes with `m1_lock`=1 for 3 beats while m0 also requests writes → `m1_gnt` on all 3 beats. When lock drops, m0 is granted on the next cycle.
- **Async reset mid-read:** a read is granted, then `rst` drops before the next edge → `mX_rvalid` stays 0 and the pointers return to 0.
- **Scoreboard:** 10k cycles of random req/we/lock/addr against a reference memory model → every read returns the last value written. There are never two grants on one port in the same cycle. No request is lost, given masters hold requests until granted.
